// File: rtl/log_seq_pkg.sv
// Shared types and constants for the log-unit sequencer.
package log_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned LOG_LAT_DEFAULT = 4;
    localparam logic [31:0] FLOOR_IN        = 32'h0080_0000;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;

    // Negative values and zero/denormal exponents are outside the log domain.
    function automatic logic needs_floor(input logic [31:0] x);
        return x[SIGN_BIT] || (x[EXP_MSB:EXP_LSB] == '0);
    endfunction

endpackage

// File: rtl/log_seq_pipe.sv
// Valid + bin-address delay line tracking reads through the sanitise and log stages.
module log_seq_pipe #(
    parameter int unsigned DEPTH      = 6,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  head_valid_o,
    output logic                  pending_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [DEPTH-1:0]      valid_q;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else begin
            valid_q   <= {valid_q[DEPTH-2:0], valid_i};
            addr_q[0] <= addr_i;
            for (int i = 1; i < DEPTH; i++) addr_q[i] <= addr_q[i-1];
        end
    end

    // Entries other than the output stage still have a write ahead of them.
    assign pending_o    = |valid_q[DEPTH-2:0];
    assign head_valid_o = valid_q[0];
    assign valid_o      = valid_q[DEPTH-1];
    assign addr_o       = addr_q[DEPTH-1];

endmodule

// File: rtl/log_seq_ctrl.sv
// Streams mel energies through the fixed-latency log unit into the log-energy buffer.
module log_seq_ctrl
    import log_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned LOG_LAT    = LOG_LAT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   n_bins,
    output logic                  busy,
    output logic                  done,
    output logic                  in_rd_en,
    output logic [ADDR_WIDTH-1:0] in_rd_addr,
    input  logic [DATA_WIDTH-1:0] in_rd_data,
    output logic                  log_ena,
    output logic [DATA_WIDTH-1:0] log_data_in,
    input  logic [DATA_WIDTH-1:0] log_data_out,
    output logic                  out_wr_en,
    output logic [ADDR_WIDTH-1:0] out_wr_addr,
    output logic [DATA_WIDTH-1:0] out_wr_data,
    output logic [ADDR_WIDTH:0]   sat_cnt
);

    localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH    = 2 + LOG_LAT;
    localparam logic [CNT_W-1:0] MAX_BINS = CNT_W'(1 << ADDR_WIDTH);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]      sat_q, sat_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] ldi_q, ldi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ena_q, ena_d;
    logic                  head_valid, pending;

    log_seq_pipe #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pipe (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (rd_en_q),
        .addr_i       (rd_addr_q),
        .head_valid_o (head_valid),
        .pending_o    (pending),
        .valid_o      (out_wr_en),
        .addr_o       (out_wr_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            rd_cnt_q  <= '0;
            sat_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            ldi_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ena_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            rd_cnt_q  <= rd_cnt_d;
            sat_q     <= sat_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            ldi_q     <= ldi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ena_q     <= ena_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        rd_cnt_d  = rd_cnt_q;
        sat_d     = sat_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        ldi_d     = ldi_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d      = (n_bins > MAX_BINS) ? MAX_BINS : n_bins;
                    rd_cnt_d = '0;
                    sat_d    = '0;
                    if (n_bins == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        // Read 0 issues straight out of the accepting edge.
                        state_d   = ST_RUN;
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                        rd_cnt_d  = CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (rd_cnt_q == n_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_cnt_q[ADDR_WIDTH-1:0];
                    rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!pending) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Sanitise the read data returning this cycle.
        if (head_valid) begin
            if (needs_floor(32'(in_rd_data))) begin
                ldi_d = DATA_WIDTH'(FLOOR_IN);
                sat_d = sat_q + CNT_W'(1);
            end else begin
                ldi_d = in_rd_data;
            end
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        ena_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign in_rd_en    = rd_en_q;
    assign in_rd_addr  = rd_addr_q;
    assign log_ena     = ena_q;
    assign log_data_in = ldi_q;
    assign sat_cnt     = sat_q;
    assign out_wr_data = out_wr_en ? log_data_out : '0;

endmodule

// File: tb/tb_log_seq_ctrl.sv
// Scoreboard bench for log_seq_ctrl with behavioural buffer and log-unit models.
module tb_log_seq_ctrl;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 6;
    localparam int unsigned LAT = 4;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [AW:0]   n_bins;
    logic          busy, done, in_rd_en, log_ena, out_wr_en;
    logic [AW-1:0] in_rd_addr, out_wr_addr;
    logic [DW-1:0] in_rd_data, log_data_in, log_data_out, out_wr_data;
    logic [AW:0]   sat_cnt;

    log_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOG_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .n_bins(n_bins),
        .busy(busy), .done(done),
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .log_ena(log_ena), .log_data_in(log_data_in), .log_data_out(log_data_out),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t wr_q[$];
    exp_t op_q[$];
    int   done_q[$];

    int tests = 0, fails = 0;
    int cyc = 0;
    int rd_seen = 0, wr_seen = 0, done_seen = 0;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] lp  [LAT];

    function automatic logic [DW-1:0] log_model(input logic [DW-1:0] x);
        return {x[15:0], x[31:16]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [DW-1:0] san_model(input logic [DW-1:0] x);
        return (x[31] || x[30:23] == 8'h00) ? 32'h0080_0000 : x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Mel energy buffer: one-cycle read latency.
    always @(posedge clk) if (in_rd_en) in_rd_data <= mem[in_rd_addr];

    // Log unit: LAT-stage pipeline advancing only while enabled.
    always @(posedge clk) begin
        if (log_ena) begin
            lp[0] <= log_model(log_data_in);
            for (int i = 1; i < LAT; i++) lp[i] <= lp[i-1];
        end
    end
    assign log_data_out = lp[LAT-1];

    // Monitor: pops expectations whenever the DUT presents a write, operand or done.
    always @(negedge clk) begin
        exp_t e;
        if (in_rd_en) rd_seen++;
        if (out_wr_en) begin
            wr_seen++;
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 64'(out_wr_en), 64'(0));
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", 64'(out_wr_addr), 64'(e.addr));
                check("wr_data", 64'(out_wr_data), 64'(e.data));
                check("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (op_q.size() != 0 && op_q[0].cyc == cyc) begin
            e = op_q.pop_front();
            check("log_operand", 64'(log_data_in), 64'(e.data));
        end
        if (done) begin
            done_seen++;
            check("done_busy", 64'(busy), 64'(1));
            if (done_q.size() == 0) check("done_unexpected", 64'(done), 64'(0));
            else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},   64'(busy), 64'(0));
        check({tag, "_done"},   64'(done), 64'(0));
        check({tag, "_rd_en"},  64'(in_rd_en), 64'(0));
        check({tag, "_ena"},    64'(log_ena), 64'(0));
        check({tag, "_wr_en"},  64'(out_wr_en), 64'(0));
        check({tag, "_rdaddr"}, 64'(in_rd_addr), 64'(0));
        check({tag, "_wraddr"}, 64'(out_wr_addr), 64'(0));
        check({tag, "_ldi"},    64'(log_data_in), 64'(0));
        check({tag, "_wrdata"}, 64'(out_wr_data), 64'(0));
        check({tag, "_sat"},    64'(sat_cnt), 64'(0));
    endtask

    // Pulses start; optionally queues the full expected response of the frame.
    task automatic start_frame(input int n, input bit push, output int t0, output int exp_sat);
        int   nc;
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        n_bins = 7'(n);
        t0     = cyc + 1;
        nc     = (n > 64) ? 64 : n;
        exp_sat = 0;
        if (push) begin
            for (int k = 0; k < nc; k++) begin
                if (san_model(mem[k]) != mem[k]) exp_sat++;
                e.cyc = t0 + 2 + k; e.addr = 6'(k); e.data = san_model(mem[k]);
                op_q.push_back(e);
                e.cyc = t0 + 2 + LAT + k; e.data = log_model(san_model(mem[k]));
                wr_q.push_back(e);
            end
            done_q.push_back((nc == 0) ? t0 : t0 + 2 + LAT + nc);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int d0 = done_seen;
        int i  = 0;
        while (done_seen == d0 && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (done_seen == d0) check("done_timeout", 64'(done_seen), 64'(d0 + 1));
    endtask

    task automatic finish_frame(input string tag, input int nc, input int exp_sat,
                                input int rd0, input int wr0, input int dn0);
        wait_done();
        repeat (3) @(negedge clk);
        check({tag, "_busy_low"}, 64'(busy), 64'(0));
        check({tag, "_sat"},      64'(sat_cnt), 64'(exp_sat));
        check({tag, "_reads"},    64'(rd_seen - rd0), 64'(nc));
        check({tag, "_writes"},   64'(wr_seen - wr0), 64'(nc));
        check({tag, "_dones"},    64'(done_seen - dn0), 64'(1));
        check({tag, "_wr_left"},  64'(wr_q.size()), 64'(0));
    endtask

    initial begin
        int t0, es, rd0, wr0, dn0;
        rst = 1'b1; start = 1'b0; n_bins = '0;
        for (int k = 0; k < 64; k++) mem[k] = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;

        // 1.0, 2.0, 4.0, 8.0: no substitutions
        mem[0] = 32'h3F80_0000; mem[1] = 32'h4000_0000;
        mem[2] = 32'h4080_0000; mem[3] = 32'h4100_0000;
        rd0 = rd_seen; wr0 = wr_seen; dn0 = done_seen;
        start_frame(4, 1'b1, t0, es);
        finish_frame("pos4", 4, 0, rd0, wr0, dn0);

        // -0, denormal, -1.0 floored; 1.0 passes
        mem[0] = 32'h8000_0000; mem[1] = 32'h0000_0001;
        mem[2] = 32'hBF80_0000; mem[3] = 32'h3F80_0000;
        rd0 = rd_seen; wr0 = wr_seen; dn0 = done_seen;
        start_frame(4, 1'b1, t0, es);
        finish_frame("sat4", 4, 3, rd0, wr0, dn0);

        rd0 = rd_seen; wr0 = wr_seen; dn0 = done_seen;
        start_frame(0, 1'b1, t0, es);
        finish_frame("zero", 0, 0, rd0, wr0, dn0);

        for (int k = 0; k < 64; k++) begin
            case (k % 5)
                0:       mem[k] = 32'h0000_0040 + 32'(k);
                1:       mem[k] = 32'hC000_0000 | 32'(k);
                default: mem[k] = 32'h3F80_0000 + 32'(k << 12);
            endcase
        end

        // Re-pulsed start during RUN must be ignored.
        rd0 = rd_seen; wr0 = wr_seen; dn0 = done_seen;
        start_frame(40, 1'b1, t0, es);
        repeat (4) @(negedge clk);
        start = 1'b1; n_bins = 7'd5;
        @(negedge clk);
        start = 1'b0;
        finish_frame("repulse", 40, es, rd0, wr0, dn0);
        repeat (10) @(negedge clk);
        check("repulse_single_done", 64'(done_seen - dn0), 64'(1));

        // Reset sampled at edge T+5 of a 10-bin frame.
        start_frame(10, 1'b0, t0, es);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("midrst");
        rd0 = rd_seen; wr0 = wr_seen; dn0 = done_seen;
        repeat (20) @(negedge clk);
        check("midrst_no_reads",  64'(rd_seen - rd0), 64'(0));
        check("midrst_no_writes", 64'(wr_seen - wr0), 64'(0));
        check("midrst_no_done",   64'(done_seen - dn0), 64'(0));

        rd0 = rd_seen; wr0 = wr_seen; dn0 = done_seen;
        start_frame(10, 1'b1, t0, es);
        finish_frame("after_rst", 10, es, rd0, wr0, dn0);

        rd0 = rd_seen; wr0 = wr_seen; dn0 = done_seen;
        start_frame(64, 1'b1, t0, es);
        finish_frame("full64", 64, es, rd0, wr0, dn0);

        rd0 = rd_seen; wr0 = wr_seen; dn0 = done_seen;
        start_frame(100, 1'b1, t0, es);
        finish_frame("clamp", 64, es, rd0, wr0, dn0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/log_seq_ctrl.md
# log_seq_ctrl

Sequencer for the floating-point log unit in the MFCC chain. On a `start` pulse it streams `n_bins` IEEE-754 single-precision mel-filterbank energies from the mel energy buffer through the fixed-latency log unit and writes the log results into the log-energy buffer. It replaces non-positive or denormal inputs with a floor value, because the log unit is undefined for them. It then pulses `done` for the DCT stage.

## Interface
- `DATA_WIDTH`, 32: sample width, IEEE-754 single.
- `ADDR_WIDTH`, 6: buffer address width; max 2^ADDR_WIDTH bins.
- `LOG_LAT`, 4: cycles from `log_data_in` to matching `log_data_out`, with `log_ena` held high.
- `FLOOR_IN`, 32'h0080_0000: substitute input (smallest normal).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `n_bins`  in  ADDR_WIDTH+1  bin count, latched on accepted `start`.
- `busy`  out  1  high from cycle after accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle completion pulse.
- `in_rd_en`  out  1  read strobe to mel energy buffer.
- `in_rd_addr`  out  ADDR_WIDTH  read address.
- `in_rd_data`  in  DATA_WIDTH  read data, valid 1 cycle after `in_rd_en`.
- `log_ena`  out  1  enable to log unit.
- `log_data_in`  out  DATA_WIDTH  registered, sanitised operand to log unit.
- `log_data_out`  in  DATA_WIDTH  log unit result.
- `out_wr_en`  out  1  write strobe to log-energy buffer.
- `out_wr_addr`  out  ADDR_WIDTH  write address.
- `out_wr_data`  out  DATA_WIDTH  equals `log_data_out` when `out_wr_en` is high.
- `sat_cnt`  out  ADDR_WIDTH+1  number of substituted inputs in the current or last frame.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`. On the same edge: latch `n_bins`, clear `rd_cnt` and `sat_cnt`. If `n_bins` is 0, go IDLE → DONE instead.
  - RUN: each cycle assert `in_rd_en`, drive `in_rd_addr` = `rd_cnt`, then increment `rd_cnt`. After the read with `rd_cnt` = `n_bins`-1, go to DRAIN.
  - DRAIN: no reads. Stay until the valid pipe is empty, then go to DONE.
  - DONE: `done` = 1 for one cycle, then IDLE.
- Sanitise stage:
  - Check `in_rd_data` one cycle after each read.
  - If sign = 1, or exponent field = 0, register `FLOOR_IN` into `log_data_in` and increment `sat_cnt`.
  - Otherwise register `in_rd_data` unchanged.
- Valid/address delay line:
  - Depth 2+LOG_LAT: read stage, sanitise register, then LOG_LAT log stages.
  - Each entry carries a valid bit and its bin address.
  - Its output drives `out_wr_en` and `out_wr_addr`.
- `log_ena` = 1 in RUN and DRAIN, 0 otherwise. The log unit therefore advances in lock-step with the delay line.
- `start` is ignored while `busy` is high; it is neither queued nor counted.
- Reset in any state:
  - FSM → IDLE; counters and valid bits cleared.
  - No `out_wr_en` or `done` on the following cycle.
  - Partial buffer contents are left as they are.
- `sat_cnt` holds its value after DONE until the next accepted `start`.

## Timing
- Reset values: `busy`, `done`, `in_rd_en`, `log_ena`, `out_wr_en` = 0; `in_rd_addr`, `out_wr_addr`, `log_data_in`, `out_wr_data`, `sat_cnt` = 0.
- Per-bin timing, with `start` accepted at edge T:
  - Read k is issued in cycle T+1+k.
  - `log_data_in` for bin k is valid in cycle T+3+k.
  - Write k occurs in cycle T+3+LOG_LAT+k.
- Reads and writes: one read and one write per cycle in steady state (throughput 1 bin/cycle), with no bubbles.
- Frame timing:
  - The last write falls in cycle T+2+LOG_LAT+n_bins.
  - `done` is asserted in the following cycle; `busy` falls after it.
  - With `n_bins` = 0: `done` in cycle T+1, with no reads or writes.
- Write addresses are strictly increasing from 0 to `n_bins`-1.
- `n_bins` greater than 2^ADDR_WIDTH is clamped to 2^ADDR_WIDTH.

## Structure
- Package `log_seq_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - `FLOOR_IN`;
  - the default `LOG_LAT`;
  - the IEEE-754 field positions: sign bit 31, exponent [30:23].
- Sub-module `log_seq_pipe`: parameterised valid+address shift register of depth 2+LOG_LAT, with synchronous clear.
- The log unit and both buffers are instantiated outside this block, at the MFCC top level.

## Test plan
- `n_bins`=4, inputs 1.0, 2.0, 4.0, 8.0, `LOG_LAT`=4, `start` at T:
  - writes at T+7..T+10, addresses 0..3, data = log unit model output;
  - `done` at T+11; `sat_cnt`=0.
- Inputs 32'h8000_0000, 32'h0000_0001, -1.0, 1.0:
  - first three operands to the log unit are `FLOOR_IN`;
  - `sat_cnt`=3.
- `n_bins`=0 → `done` one cycle after `start`; no `in_rd_en` and no `out_wr_en`.
- `start` re-pulsed during RUN with `n_bins`=40 → ignored; exactly 40 writes; a single `done`.
- `rst` at T+5 of a 10-bin frame:
  - all outputs at reset values from T+6;
  - no writes afterwards;
  - a new `start` then completes a full frame correctly.
- `n_bins`=64 (ADDR_WIDTH=6) → 64 back-to-back writes; the address reaches 63 with no wrap-around before `done`.
